mem_responder: RTL and testbench



---
 rtl/mem_responder_if.sv | 37 +++
 rtl/mem_responder.sv | 176 +++++++++++++++++
 tb/tb_mem_responder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// mem_responder_if: handshake and data bundle between the core-side initiator
// (master) and the memory responder (slave). Defining MEM_PERF_COUNT_EN adds
// the wr_count status output.
interface mem_responder_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] address;
  logic [1:0]        write;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              done;
  logic              error;
  logic              busy;
`ifdef MEM_PERF_COUNT_EN
  logic [31:0]       wr_count;

  modport master (
    output address, write, wdata,
    input  rdata, done, error, busy, wr_count
  );

  modport slave (
    input  address, write, wdata,
    output rdata, done, error, busy, wr_count
  );
`else
  modport master (
    output address, write, wdata,
    input  rdata, done, error, busy
  );

  modport slave (
    input  address, write, wdata,
    output rdata, done, error, busy
  );
`endif
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-wide on-chip RAM with a one-cycle registered read port
// and a handshaked byte/half/word write engine (accept, wait, commit, done,
// hold). Lane 0 (address offset 0) is the most significant byte of a word.
// Optional feature macro: MEM_PERF_COUNT_EN adds a 32-bit count of
// successful commits on bus.wr_count.
module mem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WRITE_LAT   = 1
) (
  input logic           clk,
  input logic           rst,
  mem_responder_if.slave bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WRITE_LAT > 1) ? $clog2(WRITE_LAT + 1) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    COMMIT,
    DONE,
    HOLD
  } state_t;

  state_t            r_state;
  state_t            w_nextState;

  logic [31:0]       r_mem [DEPTH_WORDS];
  logic [31:0]       r_rdata;
  logic [IDX_W-1:0]  r_wrIdx;
  logic [1:0]        r_wrLane;
  logic [1:0]        r_wrSize;
  logic [31:0]       r_wrData;
  logic              r_error;
  logic              r_done;
  logic [CNT_W-1:0]  r_waitCount;

  logic [ADDR_W-1:0] w_wordAddr;
  logic              w_inRange;
  logic [IDX_W-1:0]  w_addrIdx;
  logic              w_misHalf;
  logic              w_misWord;
  logic              w_accErr;
  logic              w_accept;
  logic              w_commit;
  logic              w_busy;
  logic [3:0]        w_laneEn;
  logic [31:0]       w_laneData;

  assign w_wordAddr = ADDR_W'(bus.address[ADDR_W-1:2]);
  assign w_inRange  = (w_wordAddr < DEPTH_L);
  assign w_addrIdx  = bus.address[IDX_W+1:2];
  assign w_misHalf  = (bus.write == 2'b10) && bus.address[0];
  assign w_misWord  = (bus.write == 2'b11) && (bus.address[1:0] != 2'b00);
  assign w_accErr   = w_misHalf || w_misWord || !w_inRange;
  assign w_accept   = (r_state == IDLE) && (bus.write != 2'b00);
  assign w_commit   = (r_state == COMMIT) && !r_error;

  // Next-state and busy decode; the held request only releases the FSM once write drops.
  always_comb begin
    w_nextState = r_state;
    w_busy      = (r_state != IDLE);
    case (r_state)
      IDLE:    if (bus.write != 2'b00) w_nextState = (WRITE_LAT == 0) ? COMMIT : WAIT;
      WAIT:    if (r_waitCount == CNT_W'(1)) w_nextState = COMMIT;
      COMMIT:  w_nextState = DONE;
      DONE:    w_nextState = HOLD;
      HOLD:    if (bus.write == 2'b00) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Steer latched write data onto byte lanes; half writes fill lane k then lane k+1.
  always_comb begin
    w_laneEn   = '0;
    w_laneData = '0;
    for (int k = 0; k < 4; k++) begin
      case (r_wrSize)
        2'b01: begin
          if (r_wrLane == 2'(k)) begin
            w_laneEn[k]                = 1'b1;
            w_laneData[8*(3-k) +: 8]   = r_wrData[7:0];
          end
        end
        2'b10: begin
          if (r_wrLane == 2'(k)) begin
            w_laneEn[k]                = 1'b1;
            w_laneData[8*(3-k) +: 8]   = r_wrData[15:8];
          end else if (({1'b0, r_wrLane} + 3'd1) == 3'(k)) begin
            w_laneEn[k]                = 1'b1;
            w_laneData[8*(3-k) +: 8]   = r_wrData[7:0];
          end
        end
        2'b11: begin
          w_laneEn[k]                  = 1'b1;
          w_laneData[8*(3-k) +: 8]     = r_wrData[8*(3-k) +: 8];
        end
        default: begin
        end
      endcase
    end
  end

  // FSM state, wait counter, request latch, error status and registered done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_waitCount <= '0;
      r_error     <= 1'b0;
      r_done      <= 1'b0;
      r_wrIdx     <= '0;
      r_wrLane    <= '0;
      r_wrSize    <= '0;
      r_wrData    <= '0;
    end else begin
      r_state <= w_nextState;
      r_done  <= (r_state == DONE);
      if (w_accept) begin
        r_wrIdx     <= w_addrIdx;
        r_wrLane    <= bus.address[1:0];
        r_wrSize    <= bus.write;
        r_wrData    <= bus.wdata;
        r_error     <= w_accErr;
        r_waitCount <= CNT_W'(WRITE_LAT);
      end else if (r_state == WAIT) begin
        r_waitCount <= r_waitCount - CNT_W'(1);
      end
    end
  end

  // Registered read; out-of-range words read as zero and a same-edge commit is not forwarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_inRange) begin
      r_rdata <= r_mem[w_addrIdx];
    end else begin
      r_rdata <= '0;
    end
  end

  // RAM lane writes on the commit edge; contents survive reset but reset blocks the commit.
  always_ff @(posedge clk) begin
    if (!rst && w_commit) begin
      for (int k = 0; k < 4; k++) begin
        if (w_laneEn[k]) begin
          r_mem[r_wrIdx][8*(3-k) +: 8] <= w_laneData[8*(3-k) +: 8];
        end
      end
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.done  = r_done;
  assign bus.error = r_error;
  assign bus.busy  = w_busy;

`ifdef MEM_PERF_COUNT_EN
  logic [31:0] r_wrCount;

  // Count error-free commits, wrapping naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrCount <= '0;
    end else if (w_commit) begin
      r_wrCount <= r_wrCount + 32'd1;
    end
  end

  assign bus.wr_count = r_wrCount;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed stimulus against mem_responder with a byte-level
// reference model checked every cycle, plus literal expectations per scenario.
// Honors MEM_PERF_COUNT_EN when defined for the build.
module tb_mem_responder;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 1024;
  localparam int LAT    = 1;

  logic clk;
  logic rst;

  mem_responder_if #(.ADDR_W(ADDR_W)) bus ();

  mem_responder #(
    .ADDR_W      (ADDR_W),
    .DEPTH_WORDS (DEPTH),
    .WRITE_LAT   (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int assertCount = 0;
  int failCount   = 0;
  int doneSeen    = 0;
  int doneCyc     = 0;
  int cyc         = 0;
  int mAccCyc     = 0;

  logic [7:0]  mByte  [4*DEPTH];
  bit          mKnown [4*DEPTH];
  logic        mBusy    = 1'b0;
  logic        mDone    = 1'b0;
  logic        mErr     = 1'b0;
  logic [31:0] mRd      = '0;
  bit          mRdKnown = 1'b0;
  int          mStep    = 0;
  logic [31:0] mWrCount = '0;
  logic [31:0] reqA     = '0;
  logic [31:0] reqD     = '0;
  logic [1:0]  reqW     = '0;

  // free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit modelErr(input logic [1:0] w, input logic [31:0] a);
    return ((w == 2'b10) && a[0]) || ((w == 2'b11) && (a[1:0] != 2'b00)) || ((a >> 2) >= DEPTH);
  endfunction

  task automatic setByte(input logic [31:0] a, input logic [7:0] v);
    mByte[a]  = v;
    mKnown[a] = 1'b1;
  endtask

  task automatic modelCommit();
    if (!mErr) begin
      mWrCount = mWrCount + 32'd1;
      case (reqW)
        2'b01: setByte(reqA, reqD[7:0]);
        2'b10: begin
          setByte(reqA, reqD[15:8]);
          setByte(reqA + 1, reqD[7:0]);
        end
        2'b11: for (int i = 0; i < 4; i++) setByte(reqA + i, reqD[8*(3-i) +: 8]);
        default: ;
      endcase
    end
  endtask

  // reference model advanced on each rising edge, compared on the following falling edge
  initial begin
    logic [31:0] a;
    logic [1:0]  w;
    int          base;
    forever begin
      @(posedge clk);
      cyc++;
      a = bus.address;
      w = bus.write;
      if (rst) begin
        mBusy = 1'b0; mDone = 1'b0; mErr = 1'b0;
        mRd = '0; mRdKnown = 1'b1; mStep = 0; mWrCount = '0;
      end else begin
        mDone = 1'b0;
        if ((a >> 2) >= DEPTH) begin
          mRd = '0; mRdKnown = 1'b1;
        end else begin
          base     = int'(a >> 2) * 4;
          mRd      = {mByte[base], mByte[base+1], mByte[base+2], mByte[base+3]};
          mRdKnown = mKnown[base] && mKnown[base+1] && mKnown[base+2] && mKnown[base+3];
        end
        if (!mBusy) begin
          if (w != 2'b00) begin
            mBusy = 1'b1; mStep = 0;
            reqA = a; reqW = w; reqD = bus.wdata;
            mErr = modelErr(w, a);
            mAccCyc = cyc;
          end
        end else begin
          mStep++;
          if (mStep == LAT + 1) modelCommit();
          else if (mStep == LAT + 2) mDone = 1'b1;
          else if ((mStep > LAT + 2) && (w == 2'b00)) mBusy = 1'b0;
        end
      end
      @(negedge clk);
      checkOutput("cyc_done", bus.done, mDone);
      checkOutput("cyc_busy", bus.busy, mBusy);
      checkOutput("cyc_error", bus.error, mErr);
      if (mRdKnown) checkOutput("cyc_rdata", bus.rdata, mRd);
`ifdef MEM_PERF_COUNT_EN
      checkOutput("cyc_wr_count", bus.wr_count, mWrCount);
`endif
      if (bus.done === 1'b1) begin
        doneSeen++;
        doneCyc = cyc;
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] wr, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk); #1;
    bus.write   = wr;
    bus.address = addr;
    bus.wdata   = data;
  endtask

  task automatic doWrite(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] data,
                         input int holdCycles);
    int startSeen;
    int n;
    bit got;
    startSeen = doneSeen;
    applyStimulus(sz, addr, data);
    got = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk); #1;
      n++;
      if (bus.done === 1'b1) got = 1'b1;
    end
    checkOutput("done_seen", 32'(got), 32'd1);
    if (got) checkOutput("done_latency", 32'(doneCyc - mAccCyc), 32'd3);
    if (holdCycles > 0) begin
      repeat (holdCycles) begin
        @(negedge clk); #1;
      end
      checkOutput("busy_hold", bus.busy, 1'b1);
    end
    bus.write = 2'b00;
    @(negedge clk); #1;
    checkOutput("busy_release", bus.busy, 1'b0);
    checkOutput("done_pulses", 32'(doneSeen - startSeen), 32'd1);
  endtask

  task automatic readWord(input logic [31:0] addr, input logic [31:0] exp, input string name);
    applyStimulus(2'b00, addr, 32'h0);
    @(negedge clk); #1;
    checkOutput(name, bus.rdata, exp);
  endtask

  // directed scenarios
  initial begin
`ifdef MEM_PERF_COUNT_EN
    logic [31:0] wcBefore;
`endif
    rst = 1'b1;
    bus.address = '0;
    bus.write   = 2'b00;
    bus.wdata   = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_done", bus.done, 1'b0);
    checkOutput("reset_busy", bus.busy, 1'b0);
    checkOutput("reset_error", bus.error, 1'b0);
    checkOutput("reset_rdata", bus.rdata, 32'h0);
    rst = 1'b0;

    doWrite(2'b11, 32'h10, 32'hDEADBEEF, 0);
    checkOutput("word_error", bus.error, 1'b0);
    readWord(32'h10, 32'hDEADBEEF, "read_word");

    doWrite(2'b01, 32'h13, 32'h000000A5, 0);
    readWord(32'h10, 32'hDEADBEA5, "read_byte3");
    doWrite(2'b10, 32'h10, 32'h00001234, 0);
    readWord(32'h10, 32'h1234BEA5, "read_half0");

    doWrite(2'b11, 32'h20, 32'h11111111, 0);
    checkOutput("aligned_error", bus.error, 1'b0);
    doWrite(2'b11, 32'h22, 32'h22222222, 0);
    checkOutput("misword_error", bus.error, 1'b1);
    readWord(32'h20, 32'h11111111, "read_after_misword");
    checkOutput("error_held", bus.error, 1'b1);
    doWrite(2'b11, 32'h24, 32'h33333333, 0);
    checkOutput("error_cleared", bus.error, 1'b0);
    readWord(32'h24, 32'h33333333, "read_24");

    doWrite(2'b10, 32'h11, 32'h0000BEEF, 0);
    checkOutput("mishalf_error", bus.error, 1'b1);
    readWord(32'h10, 32'h1234BEA5, "read_after_mishalf");

    doWrite(2'b11, 32'h1000, 32'hFFFFFFFF, 0);
    checkOutput("range_error", bus.error, 1'b1);
    readWord(32'h1000, 32'h0, "read_out_of_range");

`ifdef MEM_PERF_COUNT_EN
    wcBefore = bus.wr_count;
`endif
    doWrite(2'b11, 32'h30, 32'hCAFEF00D, 10);
`ifdef MEM_PERF_COUNT_EN
    checkOutput("wr_count_step", bus.wr_count - wcBefore, 32'd1);
`endif
    readWord(32'h30, 32'hCAFEF00D, "read_held");

    applyStimulus(2'b11, 32'h10, 32'h55555555);
    @(negedge clk); #1;
    checkOutput("busy_in_wait", bus.busy, 1'b1);
    rst = 1'b1;
    bus.write = 2'b00;
    @(negedge clk); #1;
    checkOutput("midreset_done", bus.done, 1'b0);
    checkOutput("midreset_busy", bus.busy, 1'b0);
    checkOutput("midreset_error", bus.error, 1'b0);
    checkOutput("midreset_rdata", bus.rdata, 32'h0);
`ifdef MEM_PERF_COUNT_EN
    checkOutput("midreset_wr_count", bus.wr_count, 32'h0);
`endif
    rst = 1'b0;
    readWord(32'h10, 32'h1234BEA5, "read_after_midreset");
    doWrite(2'b01, 32'h10, 32'h00000077, 0);
    readWord(32'h10, 32'h7734BEA5, "read_post_reset_write");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // hard stop if the scenarios never complete
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
